// File: rtl/aes_host_if.sv
// Host-side command front end for an AES core: gathers key/block words,
// sequences init/next pulses to the core and streams the 128-bit result back.
module aes_host_if #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [3:0]        status,
  output logic              core_init,
  output logic              core_next,
  output logic              core_encdec,
  output logic              core_keylen,
  output logic [255:0]      core_key,
  output logic [127:0]      core_block,
  input  logic              core_ready,
  input  logic              core_valid,
  input  logic [127:0]      core_result,
  output logic [1:0]        dbg_state
);

  if (DATA_W != 8 && DATA_W != 16 && DATA_W != 32) begin : g_bad_width
    $error("aes_host_if: DATA_W must be 8, 16 or 32");
  end

  localparam int KEY_WORDS = 256 / DATA_W;
  localparam int BLK_WORDS = 128 / DATA_W;
  localparam int KPW       = $clog2(KEY_WORDS);
  localparam int BPW       = $clog2(BLK_WORDS);

  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_CFG    = 3'd1;
  localparam logic [2:0] CMD_KEYW   = 3'd2;
  localparam logic [2:0] CMD_BLKW   = 3'd3;
  localparam logic [2:0] CMD_INIT   = 3'd4;
  localparam logic [2:0] CMD_NEXT   = 3'd5;
  localparam logic [2:0] CMD_READ   = 3'd6;
  localparam logic [2:0] CMD_CLRERR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_KEY_EXP = 2'd1,
    S_CIPHER  = 2'd2,
    S_READOUT = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Word 0 is the most significant slice; word p lives at slot ~p.
  logic [KEY_WORDS-1:0][DATA_W-1:0] key_q;
  logic [BLK_WORDS-1:0][DATA_W-1:0] blk_q;
  logic [BLK_WORDS-1:0][DATA_W-1:0] res_q;
  logic [KPW-1:0] kp_q;
  logic [BPW-1:0] bp_q;
  logic [BPW-1:0] rp_q;
  logic encdec_q, keylen_q, key_valid_q, res_avail_q, err_q;
  logic init_q, next_q;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // cmd_ready is high only in IDLE, rd_valid only in READOUT, and rd_data
  // holds its value until the word is taken.
  logic acc, rd_fire, last_rd, key_done, ciph_done;

  assign acc       = cmd_valid && cmd_ready;
  assign rd_fire   = rd_valid && rd_ready;
  assign last_rd   = (rp_q == BPW'(BLK_WORDS - 1));
  assign key_done  = (state_q == S_KEY_EXP) && !init_q && core_ready;
  assign ciph_done = (state_q == S_CIPHER) && !next_q && core_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (acc) begin
          case (cmd)
            CMD_INIT: state_d = S_KEY_EXP;
            CMD_NEXT: if (key_valid_q) state_d = S_CIPHER;
            CMD_READ: if (res_avail_q) state_d = S_READOUT;
            default:  state_d = S_IDLE;
          endcase
        end
      end
      S_KEY_EXP: if (key_done)  state_d = S_IDLE;
      S_CIPHER:  if (ciph_done) state_d = S_IDLE;
      S_READOUT: if (rd_fire && last_rd) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_q       <= '0;
      blk_q       <= '0;
      res_q       <= '0;
      kp_q        <= '0;
      bp_q        <= '0;
      rp_q        <= '0;
      encdec_q    <= 1'b0;
      keylen_q    <= 1'b0;
      key_valid_q <= 1'b0;
      res_avail_q <= 1'b0;
      err_q       <= 1'b0;
      init_q      <= 1'b0;
      next_q      <= 1'b0;
    end else begin
      init_q <= acc && (cmd == CMD_INIT);
      next_q <= acc && (cmd == CMD_NEXT) && key_valid_q;

      if (acc) begin
        case (cmd)
          CMD_CFG: begin
            encdec_q <= wdata[0];
            keylen_q <= wdata[1];
            kp_q     <= '0;
            bp_q     <= '0;
          end
          CMD_KEYW: begin
            key_q[~kp_q] <= wdata;
            kp_q         <= (kp_q == KPW'(KEY_WORDS - 1)) ? '0 : kp_q + KPW'(1);
            key_valid_q  <= 1'b0;
          end
          CMD_BLKW: begin
            blk_q[~bp_q] <= wdata;
            bp_q         <= (bp_q == BPW'(BLK_WORDS - 1)) ? '0 : bp_q + BPW'(1);
          end
          CMD_NEXT:   if (!key_valid_q) err_q <= 1'b1;
          CMD_READ: begin
            if (!res_avail_q) err_q <= 1'b1;
            rp_q <= '0;
          end
          CMD_CLRERR: err_q <= 1'b0;
          default: ;
        endcase
      end

      if (key_done) key_valid_q <= 1'b1;

      if (ciph_done) begin
        res_q       <= core_result;
        res_avail_q <= 1'b1;
      end

      if (rd_fire) begin
        if (last_rd) begin
          rp_q        <= '0;
          res_avail_q <= 1'b0;
        end else begin
          rp_q <= rp_q + BPW'(1);
        end
      end
    end
  end

  // Reset forces state to IDLE, so only cmd_ready needs explicit gating.
  assign cmd_ready   = (state_q == S_IDLE) && !reset;
  assign rd_valid    = (state_q == S_READOUT);
  assign rd_data     = rd_valid ? res_q[~rp_q] : '0;
  assign status      = {err_q, res_avail_q, key_valid_q, state_q != S_IDLE};
  assign core_init   = init_q;
  assign core_next   = next_q;
  assign core_encdec = encdec_q;
  assign core_keylen = keylen_q;
  assign core_key    = key_q;
  assign core_block  = blk_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_aes_host_if.sv
// Directed bench for aes_host_if: a 16-bit instance with a scripted core model,
// plus 8- and 32-bit instances whose core always answers at once.
module tb_aes_host_if;

  localparam logic [2:0] NOP = 3'd0, CFG = 3'd1, KEYW = 3'd2, BLKW = 3'd3;
  localparam logic [2:0] INIT = 3'd4, NEXT = 3'd5, READ = 3'd6, CLRERR = 3'd7;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int init_cnt   = 0;
  int next_cnt   = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // ---- clock / reset
  always #5 clk = ~clk;

  // ---- 16-bit instance
  logic [2:0]   cmd = NOP;
  logic         cmd_valid = 1'b0, cmd_ready;
  logic [15:0]  wdata = '0, rd_data;
  logic         rd_valid, rd_ready = 1'b0;
  logic [3:0]   status;
  logic         core_init, core_next, core_encdec, core_keylen;
  logic [255:0] core_key;
  logic [127:0] core_block;
  logic         core_ready = 1'b0, core_valid = 1'b0;
  logic [127:0] core_result = '0;
  logic [1:0]   dbg_state;

  aes_host_if #(.DATA_W(16)) dut (
    .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .wdata(wdata), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .status(status), .core_init(core_init), .core_next(core_next),
    .core_encdec(core_encdec), .core_keylen(core_keylen), .core_key(core_key),
    .core_block(core_block), .core_ready(core_ready), .core_valid(core_valid),
    .core_result(core_result), .dbg_state(dbg_state)
  );

  always @(negedge clk) begin
    if (core_init) init_cnt++;
    if (core_next) next_cnt++;
  end

  // ---- 8-bit instance
  logic [2:0]   cmd_8 = NOP;
  logic         cmd_valid_8 = 1'b0, cmd_ready_8;
  logic [7:0]   wdata_8 = '0, rd_data_8;
  logic         rd_valid_8, rd_ready_8 = 1'b0;
  logic [3:0]   status_8;
  logic         core_init_8, core_next_8, core_encdec_8, core_keylen_8;
  logic [255:0] core_key_8;
  logic [127:0] core_block_8;
  logic [127:0] res_8 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;
  logic [1:0]   dbg_state_8;

  aes_host_if #(.DATA_W(8)) dut8 (
    .clk(clk), .reset(reset), .cmd(cmd_8), .cmd_valid(cmd_valid_8), .cmd_ready(cmd_ready_8),
    .wdata(wdata_8), .rd_data(rd_data_8), .rd_valid(rd_valid_8), .rd_ready(rd_ready_8),
    .status(status_8), .core_init(core_init_8), .core_next(core_next_8),
    .core_encdec(core_encdec_8), .core_keylen(core_keylen_8), .core_key(core_key_8),
    .core_block(core_block_8), .core_ready(1'b1), .core_valid(1'b1),
    .core_result(res_8), .dbg_state(dbg_state_8)
  );

  // ---- 32-bit instance
  logic [2:0]   cmd_32 = NOP;
  logic         cmd_valid_32 = 1'b0, cmd_ready_32;
  logic [31:0]  wdata_32 = '0, rd_data_32;
  logic         rd_valid_32, rd_ready_32 = 1'b0;
  logic [3:0]   status_32;
  logic         core_init_32, core_next_32, core_encdec_32, core_keylen_32;
  logic [255:0] core_key_32;
  logic [127:0] core_block_32;
  logic [127:0] res_32 = 128'h0123456789ABCDEFFEDCBA9876543210;
  logic [1:0]   dbg_state_32;

  aes_host_if #(.DATA_W(32)) dut32 (
    .clk(clk), .reset(reset), .cmd(cmd_32), .cmd_valid(cmd_valid_32), .cmd_ready(cmd_ready_32),
    .wdata(wdata_32), .rd_data(rd_data_32), .rd_valid(rd_valid_32), .rd_ready(rd_ready_32),
    .status(status_32), .core_init(core_init_32), .core_next(core_next_32),
    .core_encdec(core_encdec_32), .core_keylen(core_keylen_32), .core_key(core_key_32),
    .core_block(core_block_32), .core_ready(1'b1), .core_valid(1'b1),
    .core_result(res_32), .dbg_state(dbg_state_32)
  );

  // ---- driver tasks: present a command at negedge, hold until accepted
  task automatic send16(input logic [2:0] c, input logic [15:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd = c; wdata = d; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    assert_cnt++;
    if (cmd_ready !== 1'b1) begin fail_cnt++; $display("FAIL send16_ready cmd=%0d got %b want 1", c, cmd_ready); end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd = NOP;
  endtask

  task automatic send8(input logic [2:0] c, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_8 = c; wdata_8 = d; cmd_valid_8 = 1'b1;
    while (cmd_ready_8 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    assert_cnt++;
    if (cmd_ready_8 !== 1'b1) begin fail_cnt++; $display("FAIL send8_ready cmd=%0d got %b want 1", c, cmd_ready_8); end
    @(posedge clk); #1;
    cmd_valid_8 = 1'b0; cmd_8 = NOP;
  endtask

  task automatic send32(input logic [2:0] c, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_32 = c; wdata_32 = d; cmd_valid_32 = 1'b1;
    while (cmd_ready_32 !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    assert_cnt++;
    if (cmd_ready_32 !== 1'b1) begin fail_cnt++; $display("FAIL send32_ready cmd=%0d got %b want 1", c, cmd_ready_32); end
    @(posedge clk); #1;
    cmd_valid_32 = 1'b0; cmd_32 = NOP;
  endtask

  // ---- scenarios
  task automatic test_reset();
    cmd = INIT; cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    assert_cnt++; if (cmd_ready !== 1'b0) begin fail_cnt++; $display("FAIL rst_cmd_ready got %b want 0", cmd_ready); end
    assert_cnt++; if (status !== 4'b0000) begin fail_cnt++; $display("FAIL rst_status got %b want 0000", status); end
    assert_cnt++; if ({rd_valid, rd_data} !== 17'h0) begin fail_cnt++; $display("FAIL rst_rd got %b/%h want 0/0000", rd_valid, rd_data); end
    assert_cnt++; if ({core_init, core_next} !== 2'b00) begin fail_cnt++; $display("FAIL rst_pulses got %b want 00", {core_init, core_next}); end
    assert_cnt++; if ({core_key, core_block} !== '0) begin fail_cnt++; $display("FAIL rst_regs got %h want 0", {core_key, core_block}); end
    reset = 1'b0; cmd_valid = 1'b0; cmd = NOP;
    #1;
    assert_cnt++; if (cmd_ready !== 1'b1) begin fail_cnt++; $display("FAIL rst_release_ready got %b want 1", cmd_ready); end
    assert_cnt++; if ({cmd_ready_8, cmd_ready_32} !== 2'b11) begin fail_cnt++; $display("FAIL rst_release_ready_w got %b want 11", {cmd_ready_8, cmd_ready_32}); end
  endtask

  task automatic test_blkw_cfg();
    logic [127:0] exp;
    logic [15:0] w;
    exp = '0;
    send16(CFG, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      w = {8'(i * 17), 8'((i + 1) * 17)};
      send16(BLKW, w);
      exp = {exp[111:0], w};
    end
    @(negedge clk);
    assert_cnt++; if (core_block !== exp) begin fail_cnt++; $display("FAIL blkw_fill got %h want %h", core_block, exp); end
    assert_cnt++; if (exp !== 128'h00111122223333444455556666777788) begin fail_cnt++; $display("FAIL blkw_table got %h want fixed", exp); end
    send16(BLKW, 16'hBEEF);
    exp[127:112] = 16'hBEEF;
    @(negedge clk);
    assert_cnt++; if (core_block !== exp) begin fail_cnt++; $display("FAIL blkw_wrap got %h want %h", core_block, exp); end
    send16(CFG, 16'h0003);
    @(negedge clk);
    assert_cnt++; if ({core_encdec, core_keylen} !== 2'b11) begin fail_cnt++; $display("FAIL cfg_bits got %b want 11", {core_encdec, core_keylen}); end
    send16(BLKW, 16'h1234);
    exp[127:112] = 16'h1234;
    @(negedge clk);
    assert_cnt++; if (core_block !== exp) begin fail_cnt++; $display("FAIL cfg_ptr_clear got %h want %h", core_block, exp); end
    send16(CFG, 16'h0000);
    @(negedge clk);
    assert_cnt++; if ({core_encdec, core_keylen} !== 2'b00) begin fail_cnt++; $display("FAIL cfg_bits0 got %b want 00", {core_encdec, core_keylen}); end
  endtask

  task automatic test_err();
    int n0;
    n0 = next_cnt;
    send16(NEXT, 16'h0);
    @(negedge clk);
    assert_cnt++; if (status !== 4'b1000) begin fail_cnt++; $display("FAIL err_next got %b want 1000", status); end
    repeat (2) @(negedge clk);
    assert_cnt++; if (next_cnt !== n0) begin fail_cnt++; $display("FAIL err_no_pulse got %0d want %0d", next_cnt, n0); end
    send16(NOP, 16'h0);
    @(negedge clk);
    assert_cnt++; if (status !== 4'b1000) begin fail_cnt++; $display("FAIL err_sticky got %b want 1000", status); end
    send16(CLRERR, 16'h0);
    @(negedge clk);
    assert_cnt++; if (status !== 4'b0000) begin fail_cnt++; $display("FAIL err_clr got %b want 0000", status); end
    send16(READ, 16'h0);
    @(negedge clk);
    assert_cnt++; if ({status, rd_valid} !== 5'b10000) begin fail_cnt++; $display("FAIL err_read got %b want 10000", {status, rd_valid}); end
    send16(CLRERR, 16'h0);
  endtask

  task automatic test_keyw();
    logic [255:0] exp;
    exp = '0;
    for (int i = 0; i < 16; i++) begin
      send16(KEYW, 16'hA000 + 16'(i));
      exp = {exp[239:0], 16'hA000 + 16'(i)};
    end
    @(negedge clk);
    assert_cnt++; if (core_key !== exp) begin fail_cnt++; $display("FAIL keyw_fill got %h want %h", core_key, exp); end
    send16(KEYW, 16'h5A5A);
    exp[255:240] = 16'h5A5A;
    @(negedge clk);
    assert_cnt++; if (core_key !== exp) begin fail_cnt++; $display("FAIL keyw_wrap got %h want %h", core_key, exp); end
  endtask

  task automatic test_init();
    int i0;
    i0 = init_cnt;
    core_ready = 1'b0;
    send16(INIT, 16'h0);
    @(negedge clk);
    assert_cnt++; if ({core_init, status[0]} !== 2'b11) begin fail_cnt++; $display("FAIL init_pulse got %b want 11", {core_init, status[0]}); end
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      assert_cnt++; if ({core_init, status} !== 5'b00001) begin fail_cnt++; $display("FAIL init_wait%0d got %b want 00001", c, {core_init, status}); end
    end
    core_ready = 1'b1;
    @(negedge clk);
    core_ready = 1'b0;
    assert_cnt++; if (status !== 4'b0010) begin fail_cnt++; $display("FAIL init_done got %b want 0010", status); end
    assert_cnt++; if (init_cnt - i0 !== 1) begin fail_cnt++; $display("FAIL init_count got %0d want 1", init_cnt - i0); end
    // core_ready already high: the pulse cycle must not complete the expansion
    core_ready = 1'b1;
    send16(INIT, 16'h0);
    @(negedge clk);
    @(negedge clk);
    assert_cnt++; if ({core_init, status[0]} !== 2'b01) begin fail_cnt++; $display("FAIL init_ignore got %b want 01", {core_init, status[0]}); end
    @(negedge clk);
    core_ready = 1'b0;
    assert_cnt++; if (status !== 4'b0010) begin fail_cnt++; $display("FAIL init_ignore_done got %b want 0010", status); end
  endtask

  task automatic test_cipher_read();
    int n0;
    n0 = next_cnt;
    core_result = 128'h000102030405060708090A0B0C0D0E0F;
    core_valid = 1'b1;
    send16(NEXT, 16'h0);
    @(negedge clk);
    assert_cnt++; if ({core_next, status[0]} !== 2'b11) begin fail_cnt++; $display("FAIL next_pulse got %b want 11", {core_next, status[0]}); end
    @(negedge clk);
    assert_cnt++; if ({core_next, status[0]} !== 2'b01) begin fail_cnt++; $display("FAIL next_ignore got %b want 01", {core_next, status[0]}); end
    @(negedge clk);
    core_valid = 1'b0;
    assert_cnt++; if (status !== 4'b0110) begin fail_cnt++; $display("FAIL cipher_done got %b want 0110", status); end
    assert_cnt++; if (next_cnt - n0 !== 1) begin fail_cnt++; $display("FAIL next_count got %0d want 1", next_cnt - n0); end
    core_result = '1;
    send16(BLKW, 16'hFFFF);
    send16(CFG, 16'h0000);
    rd_ready = 1'b0;
    send16(READ, 16'h0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      assert_cnt++; if ({rd_valid, rd_data} !== {1'b1, 16'h0001}) begin fail_cnt++; $display("FAIL rd_stall%0d got %b/%h want 1/0001", s, rd_valid, rd_data); end
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      assert_cnt++;
      if ({rd_valid, rd_data} !== {1'b1, 8'(2 * i), 8'(2 * i + 1)}) begin
        fail_cnt++; $display("FAIL rd_word%0d got %b/%h want 1/%h", i, rd_valid, rd_data, {8'(2 * i), 8'(2 * i + 1)});
      end
    end
    @(negedge clk);
    rd_ready = 1'b0;
    assert_cnt++; if ({rd_valid, status} !== 5'b00010) begin fail_cnt++; $display("FAIL rd_end got %b want 00010", {rd_valid, status}); end
    send16(KEYW, 16'h5555);
    @(negedge clk);
    assert_cnt++; if (status !== 4'b0000) begin fail_cnt++; $display("FAIL keyw_clears_kv got %b want 0000", status); end
  endtask

  task automatic test_reset_readout();
    core_result = 128'h000102030405060708090A0B0C0D0E0F;
    core_ready = 1'b1; core_valid = 1'b1; rd_ready = 1'b0;
    send16(INIT, 16'h0);
    send16(NEXT, 16'h0);
    send16(READ, 16'h0);
    core_ready = 1'b0; core_valid = 1'b0;
    @(negedge clk);
    rd_ready = 1'b1;
    repeat (3) @(negedge clk);
    rd_ready = 1'b0;
    assert_cnt++; if ({rd_valid, rd_data} !== {1'b1, 16'h0607}) begin fail_cnt++; $display("FAIL rr_word3 got %b/%h want 1/0607", rd_valid, rd_data); end
    reset = 1'b1;
    #1;
    assert_cnt++; if ({rd_valid, rd_data, status, cmd_ready} !== 22'h0) begin fail_cnt++; $display("FAIL rr_abort got %b/%h/%b/%b want 0", rd_valid, rd_data, status, cmd_ready); end
    @(negedge clk);
    reset = 1'b0;
    send16(READ, 16'h0);
    @(negedge clk);
    assert_cnt++; if ({status, rd_valid} !== 5'b10000) begin fail_cnt++; $display("FAIL rr_read_err got %b want 10000", {status, rd_valid}); end
    send16(CLRERR, 16'h0);
  endtask

  task automatic test_reset_keyexp();
    int i0;
    i0 = init_cnt;
    core_ready = 1'b0;
    send16(INIT, 16'h0);
    @(negedge clk);
    assert_cnt++; if (core_init !== 1'b1) begin fail_cnt++; $display("FAIL rk_pulse got %b want 1", core_init); end
    #1 reset = 1'b1;
    #1;
    assert_cnt++; if ({core_init, status} !== 5'b00000) begin fail_cnt++; $display("FAIL rk_abort got %b want 00000", {core_init, status}); end
    @(negedge clk);
    reset = 1'b0;
    core_ready = 1'b1;
    repeat (3) @(negedge clk);
    core_ready = 1'b0;
    assert_cnt++; if (init_cnt - i0 !== 1) begin fail_cnt++; $display("FAIL rk_count got %0d want 1", init_cnt - i0); end
    assert_cnt++; if ({status, cmd_ready} !== 5'b00001) begin fail_cnt++; $display("FAIL rk_idle got %b want 00001", {status, cmd_ready}); end
  endtask

  task automatic test_width8();
    logic [255:0] exp;
    exp = '0;
    for (int i = 0; i < 32; i++) begin
      send8(KEYW, 8'(i));
      exp = {exp[247:0], 8'(i)};
    end
    @(negedge clk);
    assert_cnt++; if (core_key_8 !== exp) begin fail_cnt++; $display("FAIL w8_key got %h want %h", core_key_8, exp); end
    rd_ready_8 = 1'b1;
    send8(INIT, 8'h0);
    send8(NEXT, 8'h0);
    send8(READ, 8'h0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      assert_cnt++;
      if ({rd_valid_8, rd_data_8} !== {1'b1, res_8[127 - 8 * i -: 8]}) begin
        fail_cnt++; $display("FAIL w8_word%0d got %b/%h want 1/%h", i, rd_valid_8, rd_data_8, res_8[127 - 8 * i -: 8]);
      end
    end
    @(negedge clk);
    rd_ready_8 = 1'b0;
    assert_cnt++; if ({rd_valid_8, status_8} !== 5'b00010) begin fail_cnt++; $display("FAIL w8_end got %b want 00010", {rd_valid_8, status_8}); end
  endtask

  task automatic test_width32();
    logic [255:0] exp;
    logic [31:0] w;
    exp = '0;
    for (int i = 0; i < 8; i++) begin
      w = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
      send32(KEYW, w);
      exp = {exp[223:0], w};
    end
    @(negedge clk);
    assert_cnt++; if (core_key_32 !== exp) begin fail_cnt++; $display("FAIL w32_key got %h want %h", core_key_32, exp); end
    rd_ready_32 = 1'b1;
    send32(INIT, 32'h0);
    send32(NEXT, 32'h0);
    send32(READ, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      assert_cnt++;
      if ({rd_valid_32, rd_data_32} !== {1'b1, res_32[127 - 32 * i -: 32]}) begin
        fail_cnt++; $display("FAIL w32_word%0d got %b/%h want 1/%h", i, rd_valid_32, rd_data_32, res_32[127 - 32 * i -: 32]);
      end
    end
    @(negedge clk);
    rd_ready_32 = 1'b0;
    assert_cnt++; if ({rd_valid_32, status_32} !== 5'b00010) begin fail_cnt++; $display("FAIL w32_end got %b want 00010", {rd_valid_32, status_32}); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_blkw_cfg();
    test_err();
    test_keyw();
    test_init();
    test_cipher_read();
    test_reset_readout();
    test_reset_keyexp();
    test_width8();
    test_width32();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
